// File: rtl/spi_target_regs_pkg.sv
// spi_tgt_pkg: shared types and constants for the SPI target register bank
package spi_tgt_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} tgt_state_e;
  localparam int CMD_RD_BIT = 7;
  localparam logic [7:0] SPI_TGT_ID = 8'hA5;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spi_target_regs_if.sv
// spi_target_regs_if: SPI pins plus local write-strobe/read port of the target
interface spi_target_regs_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  SCLK;
  logic                  CSn;
  logic                  MOSI;
  logic                  MISO;
  logic                  MISO_OE;
  logic                  WR_VALID;
  logic [ADDR_WIDTH-1:0] WR_ADDR;
  logic [7:0]            WR_DATA;
  logic [ADDR_WIDTH-1:0] REG_RADDR;
  logic [7:0]            REG_RDATA;
  logic                  INT;
  modport slave (
    input  SCLK, CSn, MOSI, REG_RADDR,
    output MISO, MISO_OE, WR_VALID, WR_ADDR, WR_DATA, REG_RDATA, INT
  );
  modport master (
    output SCLK, CSn, MOSI, REG_RADDR,
    input  MISO, MISO_OE, WR_VALID, WR_ADDR, WR_DATA, REG_RDATA, INT
  );
endinterface

// File: rtl/spi_target_regs_sync.sv
// spi_tgt_sync: multi-flop synchronizer with registered-history rise/fall detect
module spi_tgt_sync
  import spi_tgt_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // shift the pin through the synchronizer and remember the last synced value
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target with byte register bank; SPI_TGT_RO_ID_EN makes reg 0 a read-only ID
module spi_target_regs
  import spi_tgt_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic              AXI_ACLK,
  input logic              AXI_ARESETN,
  spi_target_regs_if.slave bus
);
  logic sclk_s, sclk_rise, sclk_fall;
  logic csn_s, csn_rise, csn_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  tgt_state_e             state_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   armed_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             rx_shift_q;
  logic [7:0]             tx_byte_q, tx_shift_q;
  logic [ADDR_WIDTH-1:0]  addr_q, wr_addr_q;
  logic [7:0]             wr_data_q;
  logic                   miso_q, oe_q, wr_valid_q, int_q, wr_seen_q;
  logic [7:0]             regs_q [NUM_REGS];
  logic [7:0]             byte_d;
  logic [ADDR_WIDTH-1:0]  cmd_addr;
  logic                   byte_done, wr_ok, wr_now;

  spi_tgt_sync #(.RST_VAL(1'b0)) u_sclk (.clk_i(AXI_ACLK), .rst_ni(AXI_ARESETN), .d_i(bus.SCLK),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_tgt_sync #(.RST_VAL(1'b1)) u_csn (.clk_i(AXI_ACLK), .rst_ni(AXI_ARESETN), .d_i(bus.CSn),
    .q_o(csn_s), .rise_o(csn_rise), .fall_o(csn_fall));
  spi_tgt_sync #(.RST_VAL(1'b0)) u_mosi (.clk_i(AXI_ACLK), .rst_ni(AXI_ARESETN), .d_i(bus.MOSI),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  function automatic logic [7:0] rd_reg(input logic [ADDR_WIDTH-1:0] a);
`ifdef SPI_TGT_RO_ID_EN
    return (a == '0) ? SPI_TGT_ID : regs_q[a];
`else
    return regs_q[a];
`endif
  endfunction

`ifdef SPI_TGT_RO_ID_EN
  assign wr_ok = addr_q != '0;
`else
  assign wr_ok = 1'b1;
`endif

  // incoming byte as it will look after this cycle's SCLK rise, and commit qualifiers
  always_comb begin
    byte_d    = {rx_shift_q, mosi_s};
    cmd_addr  = byte_d[ADDR_WIDTH-1:0];
    byte_done = sclk_rise && bit_cnt_q == 3'd7 && state_q != IDLE;
    wr_now    = byte_done && state_q == WDATA && wr_ok;
  end

  // frame FSM: shift on synced SCLK edges, decode bytes, end frame on CSn rise
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      armed_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= '0;
      tx_byte_q  <= '0;
      tx_shift_q <= '0;
      addr_q     <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      int_q      <= 1'b0;
      wr_seen_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q    <= armed_q | (fill_q[SYNC_STAGES-1] & csn_s);
      wr_valid_q <= 1'b0;
      int_q      <= 1'b0;
      if (state_q == IDLE) begin
        if (csn_fall && armed_q) begin
          state_q    <= CMD;
          bit_cnt_q  <= 3'd0;
          tx_byte_q  <= '0;
          tx_shift_q <= '0;
          oe_q       <= 1'b1;
        end
      end else begin
        if (sclk_rise) begin
          rx_shift_q <= byte_d[6:0];
          bit_cnt_q  <= bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD: begin
              addr_q  <= byte_d[CMD_RD_BIT] ? cmd_addr + 1'b1 : cmd_addr;
              state_q <= byte_d[CMD_RD_BIT] ? RDATA : WDATA;
              if (byte_d[CMD_RD_BIT]) tx_byte_q <= rd_reg(cmd_addr);
            end
            WDATA: begin
              if (wr_ok) begin
                regs_q[addr_q] <= byte_d;
                wr_valid_q     <= 1'b1;
                wr_addr_q      <= addr_q;
                wr_data_q      <= byte_d;
                wr_seen_q      <= 1'b1;
              end
              addr_q <= addr_q + 1'b1;
            end
            default: begin
              tx_byte_q <= rd_reg(addr_q);
              addr_q    <= addr_q + 1'b1;
            end
          endcase
        end
        if (sclk_fall) begin
          miso_q     <= bit_cnt_q == 3'd0 ? tx_byte_q[7] : tx_shift_q[7];
          tx_shift_q <= {(bit_cnt_q == 3'd0 ? tx_byte_q[6:0] : tx_shift_q[6:0]), 1'b0};
        end
        if (csn_rise) begin
          state_q   <= IDLE;
          oe_q      <= 1'b0;
          miso_q    <= 1'b0;
          int_q     <= wr_seen_q | wr_now;
          wr_seen_q <= 1'b0;
        end
      end
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.MISO_OE   = oe_q;
  assign bus.WR_VALID  = wr_valid_q;
  assign bus.WR_ADDR   = wr_addr_q;
  assign bus.WR_DATA   = wr_data_q;
  assign bus.INT       = int_q;
  assign bus.REG_RDATA = rd_reg(bus.REG_RADDR);
endmodule

// File: tb/tb_spi_target_regs.sv
// tb_spi_target_regs: scoreboard bench driving SPI frames at ACLK/8 into spi_target_regs
module tb_spi_target_regs;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_target_regs_if #(.ADDR_WIDTH(4)) bus ();
  spi_target_regs #(.NUM_REGS(16), .ADDR_WIDTH(4)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rstn), .bus(bus));

`ifdef SPI_TGT_RO_ID_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t        wr_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] miso_got[$];
  int         int_exp  = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // monitor: pop expected writes/INTs/MISO bytes as the DUT produces them
  always @(negedge clk) begin : mon
    wr_t        e;
    logic [7:0] g;
    if (bus.WR_VALID) begin
      if (wr_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: got write addr %0h data %0h, required none", bus.WR_ADDR, bus.WR_DATA);
      end else begin
        e = wr_exp.pop_front();
        chk("wr_addr", 32'(bus.WR_ADDR), 32'(e.a));
        chk("wr_data", 32'(bus.WR_DATA), 32'(e.d));
      end
    end
    if (bus.INT) begin
      chk("int_expected", 32'(int_exp > 0), 32'd1);
      if (int_exp > 0) int_exp--;
    end
    while (miso_got.size() > 0) begin
      g = miso_got.pop_front();
      if (miso_exp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL miso_unexpected: got byte %0h, required none", g);
      end else chk("miso_byte", 32'(g), 32'(miso_exp.pop_front()));
    end
  end

  task automatic xfer(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int cut, input bit cap);
    logic [7:0] b [3];
    logic [7:0] r;
    b[0] = b0; b[1] = b1; b[2] = b2;
    @(negedge clk) bus.CSn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      r = '0;
      for (int k = 7; k >= 0; k--) begin
        if (cut > 0 && i == n - 1 && 7 - k == cut) break;
        bus.MOSI = b[i][k];
        repeat (4) @(negedge clk);
        r = {r[6:0], bus.MISO};
        bus.SCLK = 1'b1;
        repeat (4) @(negedge clk);
        bus.SCLK = 1'b0;
      end
      if (cap) miso_got.push_back(r);
    end
    repeat (4) @(negedge clk);
    bus.CSn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic rd_local(input string nm, input logic [3:0] a, input logic [7:0] exp);
    bus.REG_RADDR = a;
    @(negedge clk);
    chk(nm, 32'(bus.REG_RDATA), 32'(exp));
  endtask

  task automatic drain(input string nm);
    chk({nm, "_wr_left"}, wr_exp.size(), 0);
    chk({nm, "_int_left"}, int_exp, 0);
    chk({nm, "_miso_left"}, miso_exp.size(), 0);
  endtask

  initial begin
    bus.SCLK = 1'b0;
    bus.CSn = 1'b1;
    bus.MOSI = 1'b0;
    bus.REG_RADDR = '0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_miso", 32'(bus.MISO), 0);
    chk("rst_oe", 32'(bus.MISO_OE), 0);
    chk("rst_wr_valid", 32'(bus.WR_VALID), 0);
    chk("rst_wr_addr", 32'(bus.WR_ADDR), 0);
    chk("rst_wr_data", 32'(bus.WR_DATA), 0);
    chk("rst_int", 32'(bus.INT), 0);
    rd_local("rst_reg3", 4'd3, 8'h00);
    rd_local("rst_reg0", 4'd0, RO ? 8'hA5 : 8'h00);
    // burst write with auto-increment
    wr_exp.push_back({4'd3, 8'h5A});
    wr_exp.push_back({4'd4, 8'h6B});
    int_exp++;
    xfer(3, 8'h03, 8'h5A, 8'h6B, 0, 1'b0);
    rd_local("reg4_after_write", 4'd4, 8'h6B);
    drain("write");
    // burst read back
    miso_exp.push_back(8'h00);
    miso_exp.push_back(8'h5A);
    miso_exp.push_back(8'h6B);
    xfer(3, 8'h83, 8'h00, 8'h00, 0, 1'b1);
    drain("read");
    // address wrap 15 -> 0
    wr_exp.push_back({4'd15, 8'h11});
    if (!RO) wr_exp.push_back({4'd0, 8'h22});
    int_exp++;
    xfer(3, 8'h0F, 8'h11, 8'h22, 0, 1'b0);
    rd_local("wrap_reg15", 4'd15, 8'h11);
    rd_local("wrap_reg0", 4'd0, RO ? 8'hA5 : 8'h22);
    drain("wrap");
    // partial data byte is discarded
    xfer(2, 8'h05, 8'h99, 8'h00, 5, 1'b0);
    rd_local("partial_reg5", 4'd5, 8'h00);
    drain("partial");
    wr_exp.push_back({4'd5, 8'h3C});
    int_exp++;
    xfer(2, 8'h05, 8'h3C, 8'h00, 0, 1'b0);
    rd_local("after_partial_reg5", 4'd5, 8'h3C);
    drain("after_partial");
    // CSn held low across reset release: frame must not start
    bus.CSn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.MOSI = k[0];
      repeat (4) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (4) @(negedge clk);
      bus.SCLK = 1'b0;
      chk("unarmed_oe", 32'(bus.MISO_OE), 0);
    end
    bus.CSn = 1'b1;
    repeat (10) @(negedge clk);
    rd_local("rearm_reg4", 4'd4, 8'h00);
    rd_local("rearm_reg5", 4'd5, 8'h00);
    drain("unarmed");
    wr_exp.push_back({4'd1, 8'h12});
    int_exp++;
    xfer(2, 8'h01, 8'h12, 8'h00, 0, 1'b0);
    miso_exp.push_back(8'h00);
    miso_exp.push_back(8'h12);
    xfer(2, 8'h81, 8'h00, 8'h00, 0, 1'b1);
    drain("rearmed");
    // register 0: ordinary or read-only ID
    if (!RO) begin
      wr_exp.push_back({4'd0, 8'h77});
      int_exp++;
    end
    xfer(2, 8'h00, 8'h77, 8'h00, 0, 1'b0);
    miso_exp.push_back(8'h00);
    miso_exp.push_back(RO ? 8'hA5 : 8'h77);
    xfer(2, 8'h80, 8'h00, 8'h00, 0, 1'b1);
    drain("reg0");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_target_regs.md
Name: spi_target_regs

Overview:
- SPI target (slave) with a small byte-wide register bank; it is the far end of the AXI-SPI master core.
- Used as the on-board peripheral model and as the bench responder for the master.
- Oversamples SCLK/CSn/MOSI in the AXI clock domain. SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Exposes write strobes and a local read port to surrounding logic.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; power of two.
- ADDR_WIDTH, 4, log2(NUM_REGS); at most 7.

Ports:
- AXI_ACLK  in  1  system clock; must be at least 8x the SCLK frequency.
- AXI_ARESETN  in  1  synchronous, active-low reset.
- SCLK  in  1  SPI clock, asynchronous to AXI_ACLK.
- CSn  in  1  SPI chip select, active low, asynchronous.
- MOSI  in  1  SPI data from master.
- MISO  out  1  SPI data to master.
- MISO_OE  out  1  high while a frame is active (for the tristate driver).
- WR_VALID  out  1  one-cycle pulse per committed register write.
- WR_ADDR  out  ADDR_WIDTH  address of the write; valid with WR_VALID.
- WR_DATA  out  8  data of the write; valid with WR_VALID.
- REG_RADDR  in  ADDR_WIDTH  local read address.
- REG_RDATA  out  8  combinational read of regs[REG_RADDR].
- INT  out  1  one-cycle pulse at the end of a frame that committed at least one write.

Behaviour:
- Reset values: MISO=0, MISO_OE=0, WR_VALID=0, WR_ADDR=0, WR_DATA=0, INT=0, all regs=0x00, FSM=IDLE.
- Synchronizer flops reset to SCLK=0, CSn=1, MOSI=0.
- Input sync: 2-FF synchronizer, then edge-detect register.
  - An SPI edge is acted on 3 AXI_ACLK cycles after the pin change.
- Arming: after reset, a frame starts only after the synchronized CSn has been seen high for at least 1 cycle.
  - This means CSn held low across reset release does not start a frame.
- Frame start = synchronized CSn falling edge. On start: bit_cnt=0, tx_byte=0x00, MISO_OE=1, FSM=CMD.
- On synchronized SCLK rising edge, while the frame is active:
  - rx_shift <= {rx_shift[6:0], MOSI}; bit_cnt++ (3-bit, wraps).
  - When bit_cnt was 7, the byte is complete and is processed in the same cycle, as below.
- On synchronized SCLK falling edge:
  - If bit_cnt==0: MISO <= tx_byte[7], tx_shift <= tx_byte<<1.
  - Otherwise: MISO <= tx_shift[7] and shift left.
- Byte processing by FSM state:
  - CMD: byte[7]=1 is a read, 0 is a write. addr <= byte[ADDR_WIDTH-1:0]; bits [6:ADDR_WIDTH] are ignored.
    - Read: tx_byte <= regs[addr], addr++, go to RDATA.
    - Write: go to WDATA.
  - WDATA: regs[addr] <= byte. WR_VALID pulses with WR_ADDR=addr, WR_DATA=byte. Set wr_seen. addr++.
  - RDATA: tx_byte <= regs[addr]; addr++.
- Address wraps modulo NUM_REGS: NUM_REGS-1 -> 0.
- Read data is sampled from regs at byte-completion time. A write committed in the same frame is visible to a later read.
- CSn rising edge (frame end), in any state:
  - FSM=IDLE, MISO_OE=0, MISO=0; a partial byte is discarded and never written.
  - INT pulses for 1 cycle if wr_seen; wr_seen is then cleared.
- SCLK edges while IDLE are ignored.
- A CSn rise in the same cycle as a byte completion: the byte is committed first, then the frame ends (INT includes that write).
- Reset asserted mid-frame: everything returns to reset values; the remainder of the frame is ignored until CSn goes high.
- REG_RDATA is purely combinational and has no port priority. A local read in the same cycle as an SPI write returns the old value.

Optional Feature:
- Macro SPI_TGT_RO_ID_EN.
- Defined: register 0 reads the constant ID 0xA5. SPI writes to address 0 are dropped: no WR_VALID, wr_seen not set, address still increments.
- Undefined: register 0 is an ordinary read/write register.

Decomposition:
- Package spi_tgt_pkg holds:
  - FSM state encoding: IDLE, CMD, WDATA, RDATA.
  - CMD_RD_BIT=7.
  - SPI_TGT_ID=8'hA5.
  - SYNC_STAGES=2.
- One sub-module, spi_tgt_sync: 2-FF synchronizer plus rise/fall detect.
  - Instantiated 3 times (SCLK, CSn, MOSI); edge outputs are used only for SCLK and CSn.

Test Plan:
- Write frame 0x03,0x5A,0x6B (SCLK = ACLK/8) -> WR_VALID twice, (3,0x5A) then (4,0x6B); INT one pulse after CSn rise; REG_RDATA at address 4 = 0x6B.
- After the above, read frame 0x83,0x00,0x00 -> MISO bytes 0x00,0x5A,0x6B; no INT.
- Write 0x0F,0x11,0x22 (NUM_REGS=16) -> regs[15]=0x11, regs[0]=0x22 (address wrap).
- CSn raised after 5 bits of the data byte in a write -> no WR_VALID, no INT, register unchanged; the next frame decodes normally.
- CSn held low through reset release, then 16 SCLK cycles -> no writes, MISO_OE=0; after CSn goes high then low, frames work.
- With SPI_TGT_RO_ID_EN: write 0x00,0x77 then read 0x80,0x00 -> no WR_VALID, no INT, read returns 0xA5. Without it: read returns 0x77.
